display_mux: RTL and testbench

Time-multiplexed driver for the board's 4-digit common-anode seven-segment display. It sits directly downstream of the button/anode logic and replaces its static anode assignments. It latches a 16-bit hexadecimal value, then scans the four digits at a fixed refresh rate. Each digit's nibble is decoded to segments, and each digit slot begins with a short all-off blanking interval to suppress ghosting.

---
 rtl/display_mux.sv | 104 ++++++++++
 tb/tb_display_mux.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/display_mux.sv
// Time-multiplexed driver for a 4-digit common-anode seven-segment display.
// Optional leading-zero blanking is enabled by defining DISPLAY_LZB_EN.
module display_mux #(
    parameter int REFRESH_DIV = 100000,
    parameter int BLANK       = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] dato,
    input  logic        cargar,
    input  logic        habilitar,
    output logic [3:0]  ane,
    output logic [6:0]  seg,
    output logic        dp
);

    localparam int             CW      = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CW-1:0]  CNT_MAX = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0]  BLANK_C = CW'(BLANK);

    logic [15:0]   dato_reg;
    logic [CW-1:0] cnt;
    logic [1:0]    idx;
    logic [3:0]    nibble;
    logic [6:0]    dec;
    logic          lz_dark;
    logic          dark;
    logic [3:0]    next_ane;
    logic [6:0]    next_seg;

    // Loading is independent of the scan so a reload never shifts digit timing.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dato_reg <= '0;
            cnt      <= '0;
            idx      <= '0;
        end else begin
            if (cargar) begin
                dato_reg <= dato;
            end
            if (cnt == CNT_MAX) begin
                cnt <= '0;
                idx <= idx + 2'd1;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

    always_comb begin
        nibble = dato_reg[{idx, 2'b00} +: 4];
        case (nibble)
            4'h0:    dec = 7'b1000000;
            4'h1:    dec = 7'b1111001;
            4'h2:    dec = 7'b0100100;
            4'h3:    dec = 7'b0110000;
            4'h4:    dec = 7'b0011001;
            4'h5:    dec = 7'b0010010;
            4'h6:    dec = 7'b0000010;
            4'h7:    dec = 7'b1111000;
            4'h8:    dec = 7'b0000000;
            4'h9:    dec = 7'b0010000;
            4'hA:    dec = 7'b0001000;
            4'hB:    dec = 7'b0000011;
            4'hC:    dec = 7'b1000110;
            4'hD:    dec = 7'b0100001;
            4'hE:    dec = 7'b0000110;
            default: dec = 7'b0001110;
        endcase
    end

`ifdef DISPLAY_LZB_EN
    // A digit goes dark when it and every more significant nibble are zero.
    always_comb begin
        case (idx)
            2'd3:    lz_dark = (dato_reg[15:12] == 4'h0);
            2'd2:    lz_dark = (dato_reg[15:8] == 8'h00);
            2'd1:    lz_dark = (dato_reg[15:4] == 12'h000);
            default: lz_dark = 1'b0;
        endcase
    end
`else
    assign lz_dark = 1'b0;
`endif

    always_comb begin
        dark     = (cnt < BLANK_C) || !habilitar || lz_dark;
        next_ane = dark ? 4'b1111 : ~(4'b0001 << idx);
        next_seg = dark ? 7'b1111111 : dec;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ane <= 4'b1111;
            seg <= 7'b1111111;
        end else begin
            ane <= next_ane;
            seg <= next_seg;
        end
    end

    assign dp = 1'b1;

endmodule

// File: tb/tb_display_mux.sv
// Bench for display_mux: directed scenarios plus random loads, checked against
// a cycle-count model of the scan (honours DISPLAY_LZB_EN when defined).
module tb_display_mux;

    localparam int RD = 8;
    localparam int BL = 2;

    logic        clk;
    logic        rst;
    logic [15:0] dato;
    logic        cargar;
    logic        habilitar;
    logic [3:0]  ane;
    logic [6:0]  seg;
    logic        dp;

    int          tests = 0;
    int          fails = 0;
    int          p;        // clock edges since reset release
    logic [15:0] m_dato;   // model of the displayed value

    logic [6:0] hex_tab [0:15] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    display_mux #(.REFRESH_DIV(RD), .BLANK(BL)) dut (
        .clk       (clk),
        .rst       (rst),
        .dato      (dato),
        .cargar    (cargar),
        .habilitar (habilitar),
        .ane       (ane),
        .seg       (seg),
        .dp        (dp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
        tests++;
        assert (obs === exp_v) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h at p=%0d", tag, obs, exp_v, p);
        end
    endtask

    // One clock edge: predict outputs from the pre-edge scan position, then compare.
    task automatic step();
        logic [3:0]  e_ane;
        logic [6:0]  e_seg;
        logic [15:0] upper;
        logic        ld;
        logic [15:0] ld_v;
        bit          dark;
        int          pos;
        int          d;
        pos   = p % RD;
        d     = (p / RD) % 4;
        upper = m_dato >> (4 * d);
        dark  = (pos < BL) || !habilitar;
`ifdef DISPLAY_LZB_EN
        if (d > 0 && upper == 16'h0) dark = 1'b1;
`endif
        e_ane = dark ? 4'b1111 : ~(4'b0001 << d);
        e_seg = dark ? 7'b1111111 : hex_tab[upper & 16'hF];
        ld    = cargar;
        ld_v  = dato;
        @(posedge clk);
        if (ld) m_dato = ld_v;
        p++;
        @(negedge clk);
        chk("ane", {12'h0, ane}, {12'h0, e_ane});
        chk("seg", {9'h0, seg}, {9'h0, e_seg});
        chk("dp", {15'h0, dp}, 16'h1);
        chk("onehot", {15'h0, ($countones(~ane) <= 1)}, 16'h1);
    endtask

    initial begin
        rst       = 1'b1;
        dato      = 16'h0000;
        cargar    = 1'b0;
        habilitar = 1'b1;
        p         = 0;
        m_dato    = 16'h0000;

        // Reset holds the display dark
        repeat (3) @(negedge clk);
        chk("rst_ane", {12'h0, ane}, 16'h000F);
        chk("rst_seg", {9'h0, seg}, 16'h007F);
        chk("rst_dp", {15'h0, dp}, 16'h1);
        rst = 1'b0;

        // Zero value, digit 0 appears after the blanking cycles
        repeat (RD) step();

        // Load 12AF and watch a full scan
        dato   = 16'h12AF;
        cargar = 1'b1;
        step();
        cargar = 1'b0;
        repeat (4 * RD) step();

        // Display disabled for 40 cycles, scan keeps running
        habilitar = 1'b0;
        repeat (40) step();
        habilitar = 1'b1;
        repeat (2 * RD) step();

        // Load coinciding with a slot wrap
        while (p % RD != RD - 1) step();
        dato   = 16'h3C5E;
        cargar = 1'b1;
        step();
        cargar = 1'b0;
        repeat (12) step();

        // Leading zeros
        dato   = 16'h0050;
        cargar = 1'b1;
        step();
        cargar = 1'b0;
        repeat (4 * RD) step();

        // Asynchronous reset in the middle of digit 2's active phase
        dato   = 16'h9B7D;
        cargar = 1'b1;
        step();
        cargar = 1'b0;
        while (p % (4 * RD) != 2 * RD + 4) step();
        #1 rst = 1'b1;
        #1;
        chk("async_ane", {12'h0, ane}, 16'h000F);
        chk("async_seg", {9'h0, seg}, 16'h007F);
        @(negedge clk);
        @(negedge clk);
        rst    = 1'b0;
        p      = 0;
        m_dato = 16'h0000;
        repeat (12) step();

        // Random loads and enables
        repeat (400) begin
            dato      = 16'($urandom) >> (4 * $urandom_range(0, 4));
            cargar    = ($urandom_range(0, 3) == 0);
            habilitar = ($urandom_range(0, 7) != 0);
            step();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
